// File: rtl/otter_io_pkg.sv
// Shared I/O timing constants and state encodings for the otter board
// peripherals: the event pulse stretcher and the button debouncer.
package otter_io_pkg;

    typedef enum logic [1:0] {
        ST_idle = 2'd0,
        ST_high = 2'd1,
        ST_gap  = 2'd2
    } pulse_state_t;

    localparam logic [15:0] HIGH_CLKS_DEFAULT = 16'd50;
    localparam logic [15:0] LOW_CLKS_DEFAULT  = 16'd25;
    localparam logic [3:0]  MAX_PEND_DEFAULT  = 4'd7;

    localparam logic [15:0] DEBOUNCE_CLKS_DEFAULT = 16'd10000;
    localparam int          DEBOUNCE_SYNC_STAGES  = 2;

endpackage

// File: rtl/cycle_counter.sv
// 16-bit cycle counter with synchronous clear, gated increment and a
// terminal-match flag; it holds at the terminal value instead of wrapping.
module cycle_counter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        inc,
    input  logic [15:0] terminal,
    output logic        match
);

    logic [15:0] count_reg;

    assign match = (count_reg == terminal);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= 16'd0;
        end else if (clr) begin
            count_reg <= 16'd0;
        end else if (inc && !match) begin
            count_reg <= count_reg + 16'd1;
        end
    end

endmodule

// File: rtl/event_pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width pulses separated by a
// minimum low gap, queueing events that arrive while a pulse is in progress.
module event_pulse_stretcher
    import otter_io_pkg::*;
#(
    parameter logic [15:0] HIGH_CLKS = HIGH_CLKS_DEFAULT,
    parameter logic [15:0] LOW_CLKS  = LOW_CLKS_DEFAULT,
    parameter logic [3:0]  MAX_PEND  = MAX_PEND_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EVT,
    output logic       OUT,
    output logic       BUSY,
    output logic [3:0] PEND,
    output logic       DROP
);

    pulse_state_t state_reg, state_next;
    logic [3:0]   pend_reg, pend_next;
    logic         out_reg;
    logic         accept;
    logic         take;
    logic         cnt_match;
    logic [15:0]  cnt_terminal;

    assign cnt_terminal = (state_reg == ST_high) ? (HIGH_CLKS - 16'd1) : (LOW_CLKS - 16'd1);

    cycle_counter u_cycle_counter (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (state_next != state_reg),
        .inc      (state_reg != ST_idle),
        .terminal (cnt_terminal),
        .match    (cnt_match)
    );

    // accept: EVT joins the queue; take: a queued event starts a pulse now.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        take       = 1'b0;
        case (state_reg)
            ST_idle: begin
                if (pend_reg != 4'd0) begin
                    state_next = ST_high;
                    take       = 1'b1;
                    accept     = EVT;
                end else if (EVT) begin
                    state_next = ST_high;
                end
            end
            ST_high: begin
                accept = EVT;
                if (cnt_match) begin
                    state_next = ST_gap;
                end
            end
            ST_gap: begin
                accept = EVT;
                if (cnt_match) begin
                    if (pend_reg != 4'd0) begin
                        state_next = ST_high;
                        take       = 1'b1;
                    end else begin
                        state_next = ST_idle;
                    end
                end
            end
            default: begin
                state_next = ST_idle;
            end
        endcase
    end

    always_comb begin
        pend_next = pend_reg;
        DROP      = 1'b0;
        if (accept && !take) begin
            if (pend_reg == MAX_PEND) begin
                DROP = 1'b1;
            end else begin
                pend_next = pend_reg + 4'd1;
            end
        end else if (take && !accept) begin
            pend_next = pend_reg - 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_idle;
            pend_reg  <= 4'd0;
            out_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            out_reg   <= (state_next == ST_high);
        end
    end

    assign OUT  = out_reg;
    assign BUSY = (state_reg != ST_idle);
    assign PEND = pend_reg;

endmodule
